// File: rtl/mux_4_1_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: accepts a 4-bit word and a channel mask,
// steps the mux select through the enabled channels in ascending order,
// and emits one sample strobe per channel after DWELL cycles.
module mux_4_1_scan_ctrl #(
   parameter int unsigned DWELL = 1,
   parameter int unsigned CNT_W = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_data,
   input  logic [3:0] in_mask,
   input  logic       abort,
   output logic [3:0] mux_i,
   output logic [1:0] mux_s,
   input  logic       mux_y,
   output logic       out_valid,
   output logic       out_bit,
   output logic [1:0] out_ch,
   output logic       out_last,
   output logic       busy
);

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   state_t           state;
   logic [3:0]       mask_q;
   logic [CNT_W-1:0] dwell_cnt;

   logic [3:0]       higher_mask;
   logic             has_higher;
   logic [1:0]       next_ch;

   // Index of the lowest set bit; 0 when the mask is empty.
   function automatic logic [1:0] lowest_ch(input logic [3:0] m);
      logic [1:0] ch;
      ch = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i]) ch = 2'(i);
      end
      return ch;
   endfunction

   // Enabled channels strictly above the current select, and the next one to visit.
   always_comb begin
      higher_mask = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         if (i > int'(mux_s)) higher_mask[i] = mask_q[i];
      end
      has_higher = |higher_mask;
      next_ch    = lowest_ch(higher_mask);
   end

   // Ready is a direct decode of IDLE so the last strobe and the next handshake share a cycle.
   assign in_ready = (state == ST_IDLE) && !rst;

   // Scan state machine with registered mux drive and sample outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         mask_q    <= 4'b0000;
         dwell_cnt <= '0;
         mux_i     <= 4'b0000;
         mux_s     <= 2'd0;
         out_valid <= 1'b0;
         out_bit   <= 1'b0;
         out_ch    <= 2'd0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               // An empty mask is consumed without leaving IDLE.
               if (in_valid && (in_mask != 4'b0000)) begin
                  mux_i     <= in_data;
                  mask_q    <= in_mask;
                  mux_s     <= lowest_ch(in_mask);
                  dwell_cnt <= '0;
                  busy      <= 1'b1;
                  state     <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (abort) begin
                  // Drop the remaining channels; no sample at this edge.
                  mux_s     <= 2'd0;
                  dwell_cnt <= '0;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end else if (dwell_cnt == DWELL_LAST) begin
                  out_valid <= 1'b1;
                  out_bit   <= mux_y;
                  out_ch    <= mux_s;
                  out_last  <= !has_higher;
                  dwell_cnt <= '0;
                  if (has_higher) begin
                     mux_s <= next_ch;
                  end else begin
                     busy  <= 1'b0;
                     state <= ST_IDLE;
                  end
               end else begin
                  dwell_cnt <= dwell_cnt + CNT_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_4_1_scan_ctrl.sv
// Bench for mux_4_1_scan_ctrl: three instances with DWELL = 1, 2, 3,
// each driving a behavioural 4:1 mux whose output feeds back into mux_y.
module tb_mux_4_1_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] in_valid;
   logic [2:0] abort;
   logic [3:0] in_data [3];
   logic [3:0] in_mask [3];
   logic [3:0] mux_i   [3];
   logic [1:0] mux_s   [3];
   logic [1:0] out_ch  [3];
   logic [2:0] in_ready;
   logic [2:0] mux_y;
   logic [2:0] out_valid;
   logic [2:0] out_bit;
   logic [2:0] out_last;
   logic [2:0] busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Instance g scans with DWELL = g + 1.
   for (genvar g = 0; g < 3; g++) begin : g_dut
      mux_4_1_scan_ctrl #(.DWELL(g + 1), .CNT_W(4)) u_dut (
         .clk      (clk),
         .rst      (rst),
         .in_valid (in_valid[g]),
         .in_ready (in_ready[g]),
         .in_data  (in_data[g]),
         .in_mask  (in_mask[g]),
         .abort    (abort[g]),
         .mux_i    (mux_i[g]),
         .mux_s    (mux_s[g]),
         .mux_y    (mux_y[g]),
         .out_valid(out_valid[g]),
         .out_bit  (out_bit[g]),
         .out_ch   (out_ch[g]),
         .out_last (out_last[g]),
         .busy     (busy[g])
      );
      assign mux_y[g] = mux_i[g][mux_s[g]];
   end

   typedef struct {
      logic [3:0] data;
      logic [3:0] mask;
      int         n;
      logic [7:0] chs;
      logic [3:0] bits;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // Hand one word to instance u and check every strobe, its timing and the handshake window.
   task automatic scan_word(input int u, input logic [3:0] data, input logic [3:0] mask,
                            input int n, input logic [7:0] chs, input logic [3:0] bits,
                            input logic chk_odd, input string name);
      int dw       = u + 1;
      int budget   = n * dw + 3;
      int seen     = 0;
      int busy_cyc = 0;
      int nrdy_cyc = 0;
      int odd_sel  = 0;
      check({name, " ready_before"}, int'(in_ready[u]), 1);
      in_valid[u] = 1'b1;
      in_data[u]  = data;
      in_mask[u]  = mask;
      @(posedge clk); #1;
      in_valid[u] = 1'b0;
      for (int c = 0; c <= budget; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         if (busy[u]) busy_cyc++;
         if (!in_ready[u]) nrdy_cyc++;
         if (busy[u] && (mux_s[u] == 2'd1 || mux_s[u] == 2'd3)) odd_sel++;
         if (out_valid[u]) begin
            if (seen < n) begin
               check({name, " ch"},    int'(out_ch[u]),   int'(chs[2*seen +: 2]));
               check({name, " bit"},   int'(out_bit[u]),  int'(bits[seen]));
               check({name, " last"},  int'(out_last[u]), (seen == n - 1) ? 1 : 0);
               check({name, " cycle"}, c,                 (seen + 1) * dw);
               check({name, " ready_at_strobe"}, int'(in_ready[u]), (seen == n - 1) ? 1 : 0);
            end
            seen++;
         end
      end
      check({name, " strobes"},    seen,     n);
      check({name, " busy_cyc"},   busy_cyc, n * dw);
      check({name, " nready_cyc"}, nrdy_cyc, n * dw);
      if (chk_odd) check({name, " odd_select"}, odd_sel, 0);
   endtask

   task automatic check_reset_outputs(input int u, input string name);
      check({name, " out_valid"}, int'(out_valid[u]), 0);
      check({name, " out_bit"},   int'(out_bit[u]),   0);
      check({name, " out_ch"},    int'(out_ch[u]),    0);
      check({name, " out_last"},  int'(out_last[u]),  0);
      check({name, " mux_i"},     int'(mux_i[u]),     0);
      check({name, " mux_s"},     int'(mux_s[u]),     0);
      check({name, " busy"},      int'(busy[u]),      0);
   endtask

   initial begin
      vecs[0] = '{4'b1010, 4'b1111, 4, 8'b11_10_01_00, 4'b1010};
      vecs[1] = '{4'b0110, 4'b0101, 2, 8'b00_00_10_00, 4'b0010};
      vecs[2] = '{4'b1111, 4'b1000, 1, 8'b00_00_00_11, 4'b0001};
      vecs[3] = '{4'b0001, 4'b0001, 1, 8'b00_00_00_00, 4'b0001};
      vecs[4] = '{4'b1001, 4'b0110, 2, 8'b00_00_10_01, 4'b0000};
      vecs[5] = '{4'b1111, 4'b0000, 0, 8'b00_00_00_00, 4'b0000};
      vecs[6] = '{4'b1100, 4'b1010, 2, 8'b00_00_11_01, 4'b0010};

      rst      = 1'b1;
      in_valid = 3'b000;
      abort    = 3'b000;
      for (int u = 0; u < 3; u++) begin
         in_data[u] = 4'b0000;
         in_mask[u] = 4'b0000;
      end

      // Reset values, then ready after release.
      #1;
      for (int u = 0; u < 3; u++) check_reset_outputs(u, "reset");
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      #1;
      for (int u = 0; u < 3; u++) check("reset ready", int'(in_ready[u]), 1);
      @(posedge clk); #1;

      // Table of single words through the DWELL=1 instance.
      for (int i = 0; i < 7; i++) begin
         scan_word(0, vecs[i].data, vecs[i].mask, vecs[i].n, vecs[i].chs, vecs[i].bits,
                   1'b0, $sformatf("vec%0d", i));
      end

      // DWELL=3, sparse mask: select must skip channels 1 and 3.
      scan_word(2, 4'b0110, 4'b0101, 2, 8'b00_00_10_00, 4'b0010, 1'b1, "dwell3");

      // Back-to-back words with in_valid held high on the DWELL=1 instance.
      in_valid[0] = 1'b1;
      in_data[0]  = 4'b1111;
      in_mask[0]  = 4'b1000;
      @(posedge clk); #1;
      in_data[0]  = 4'b0001;
      in_mask[0]  = 4'b0001;
      @(posedge clk); #1;
      check("b2b first valid", int'(out_valid[0]), 1);
      check("b2b first ch",    int'(out_ch[0]),    3);
      check("b2b first bit",   int'(out_bit[0]),   1);
      check("b2b first last",  int'(out_last[0]),  1);
      check("b2b first ready", int'(in_ready[0]),  1);
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      check("b2b accepted busy", int'(busy[0]),      1);
      check("b2b gap valid",     int'(out_valid[0]), 0);
      @(posedge clk); #1;
      check("b2b second valid", int'(out_valid[0]), 1);
      check("b2b second ch",    int'(out_ch[0]),    0);
      check("b2b second bit",   int'(out_bit[0]),   1);
      check("b2b second last",  int'(out_last[0]),  1);
      @(posedge clk); #1;

      // Abort during the channel-1 dwell on the DWELL=2 instance.
      in_valid[1] = 1'b1;
      in_data[1]  = 4'b0011;
      in_mask[1]  = 4'b1111;
      @(posedge clk); #1;
      in_valid[1] = 1'b0;
      @(posedge clk); #1;
      check("abort pre valid", int'(out_valid[1]), 0);
      @(posedge clk); #1;
      check("abort ch0 valid", int'(out_valid[1]), 1);
      check("abort ch0 ch",    int'(out_ch[1]),    0);
      check("abort ch0 bit",   int'(out_bit[1]),   1);
      check("abort ch0 last",  int'(out_last[1]),  0);
      check("abort ch1 sel",   int'(mux_s[1]),     1);
      abort[1] = 1'b1;
      @(posedge clk); #1;
      abort[1] = 1'b0;
      check("abort mux_s", int'(mux_s[1]),     0);
      check("abort ready", int'(in_ready[1]),  1);
      check("abort busy",  int'(busy[1]),      0);
      check("abort valid", int'(out_valid[1]), 0);
      begin
         int extra = 0;
         for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid[1]) extra++;
         end
         check("abort no more strobes", extra, 0);
      end

      // Abort while IDLE must not block a handshake.
      abort[1]    = 1'b1;
      in_valid[1] = 1'b1;
      in_data[1]  = 4'b0100;
      in_mask[1]  = 4'b0100;
      @(posedge clk); #1;
      abort[1]    = 1'b0;
      in_valid[1] = 1'b0;
      check("idle abort busy",  int'(busy[1]),     1);
      check("idle abort mux_s", int'(mux_s[1]),    2);
      check("idle abort ready", int'(in_ready[1]), 0);
      @(posedge clk); @(posedge clk); #1;
      check("idle abort valid", int'(out_valid[1]), 1);
      check("idle abort bit",   int'(out_bit[1]),   1);
      check("idle abort last",  int'(out_last[1]),  1);
      @(posedge clk); #1;

      // Reset mid-scan on the DWELL=3 instance with a strobe showing.
      in_valid[2] = 1'b1;
      in_data[2]  = 4'b1111;
      in_mask[2]  = 4'b1111;
      @(posedge clk); #1;
      in_valid[2] = 1'b0;
      @(posedge clk); @(posedge clk); @(posedge clk); #1;
      check("mid rst strobe before", int'(out_valid[2]), 1);
      #2 rst = 1'b1;
      #1;
      check_reset_outputs(2, "mid rst");
      #1 rst = 1'b0;
      #1;
      check("mid rst ready", int'(in_ready[2]), 1);
      @(posedge clk); #1;
      scan_word(2, 4'b1010, 4'b0110, 2, 8'b00_00_10_01, 4'b0001, 1'b0, "after rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
